// File: rtl/uart_cmd_parser_pkg.sv
// rtl/uart_cmd_parser_pkg.sv - shared ASCII constants, datapath width and hex-digit decode
package uart_cmd_parser_pkg;

  localparam int SEQ_DP_WIDTH = 8;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_W     = 8'h57;

  // Inverse of the nibble-to-ASCII converter: returns {valid, nib}.
  function automatic logic [4:0] fnASCII2Nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - parses ASCII "Wd:hh" / "Rd" lines into register commands
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int DW          = SEQ_DP_WIDTH,
  parameter int NUM_REG     = 4,
  parameter int TIMEOUT_CYC = 1000000,
  localparam int REG_W      = (NUM_REG > 1) ? $clog2(NUM_REG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_cmd_valid,
  input  logic             i_cmd_ready,
  output logic             o_cmd_wr,
  output logic [REG_W-1:0] o_cmd_reg,
  output logic [DW-1:0]    o_cmd_data,
  output logic             o_err,
  output logic [7:0]       o_err_cnt
);

  localparam int CNT_W = $clog2(DW / 4 + 1);
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW / 4 - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_REG, ST_COLON, ST_DATA, ST_EOL, ST_ISSUE, ST_DISCARD
  } state_e;

  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic               wr_q, wr_d;
  logic [REG_W-1:0]   reg_q, reg_d;
  logic [DW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic [7:0] rx_up;
  logic [4:0] hex;
  logic       is_eol, is_reg_digit, timing_st;

  always_comb begin
    rx_up        = (i_rx_data >= 8'h61 && i_rx_data <= 8'h7A) ? i_rx_data - 8'h20 : i_rx_data;
    hex          = fnASCII2Nib(i_rx_data);
    is_eol       = (i_rx_data == ASCII_CR) || (i_rx_data == ASCII_LF);
    is_reg_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39) &&
                   ({28'd0, i_rx_data[3:0]} < NUM_REG);
    timing_st    = (state_q == ST_REG) || (state_q == ST_COLON) ||
                   (state_q == ST_DATA) || (state_q == ST_EOL);
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    wr_d      = wr_q;
    reg_d     = reg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;

    if (i_rx_valid) begin
      tmo_d = '0;
    end else if (timing_st) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      ST_IDLE: if (i_rx_valid) begin
        // acc is cleared at line start so reads present zero data
        if (rx_up == ASCII_W || rx_up == ASCII_R) begin
          state_d = ST_REG;
          wr_d    = (rx_up == ASCII_W);
          acc_d   = '0;
        end else if (!is_eol && i_rx_data != ASCII_SPACE) begin
          state_d = ST_DISCARD;
          err_d   = 1'b1;
        end
      end
      ST_REG: if (i_rx_valid) begin
        if (is_reg_digit) begin
          reg_d   = REG_W'(i_rx_data[3:0]);
          state_d = wr_q ? ST_COLON : ST_EOL;
        end else begin
          state_d = ST_DISCARD;
          err_d   = 1'b1;
        end
      end
      ST_COLON: if (i_rx_valid) begin
        if (i_rx_data == ASCII_COLON) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = ST_DISCARD;
          err_d   = 1'b1;
        end
      end
      ST_DATA: if (i_rx_valid) begin
        if (hex[4]) begin
          acc_d = (acc_q << 4) | DW'(hex[3:0]);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = ST_EOL;
        end else if (is_eol) begin
          if (cnt_q != '0) begin
            state_d = ST_ISSUE;
            valid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_DISCARD;
          err_d   = 1'b1;
        end
      end
      ST_EOL: if (i_rx_valid) begin
        if (is_eol) begin
          state_d = ST_ISSUE;
          valid_d = 1'b1;
        end else begin
          state_d = ST_DISCARD;
          err_d   = 1'b1;
        end
      end
      ST_ISSUE: begin
        err_d = i_rx_valid;
        if (i_cmd_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      ST_DISCARD: if (i_rx_valid && is_eol) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (TIMEOUT_CYC != 0 && timing_st && !i_rx_valid && tmo_q == TMO_MAX) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end

    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      wr_q      <= 1'b0;
      reg_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      wr_q      <= wr_d;
      reg_q     <= reg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_cmd_valid = valid_q;
  assign o_cmd_wr    = wr_q;
  assign o_cmd_reg   = reg_q;
  assign o_cmd_data  = acc_q;
  assign o_err       = err_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid, cmd_wr, err;
  logic [1:0] cmd_reg;
  logic [7:0] cmd_data, err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_pulses = 0, valid_cycles = 0, fld_chg = 0;
  int err_cyc = 0, colon_edge = 0;
  int e0, v0;
  logic       prev_valid = 1'b0;
  logic [10:0] prev_fld = '0;

  uart_cmd_parser #(.DW(8), .NUM_REG(4), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
    .o_cmd_wr(cmd_wr), .o_cmd_reg(cmd_reg), .o_cmd_data(cmd_data),
    .o_err(err), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (err) begin
        err_pulses <= err_pulses + 1;
        err_cyc    <= cyc;
      end
      if (cmd_valid) valid_cycles <= valid_cycles + 1;
      if (cmd_valid && prev_valid && {cmd_wr, cmd_reg, cmd_data} != prev_fld)
        fld_chg <= fld_chg + 1;
    end
    prev_valid <= cmd_valid;
    prev_fld   <= {cmd_wr, cmd_reg, cmd_data};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    if (b == 8'h3A) colon_edge = cyc + 1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic mark();
    e0 = err_pulses;
    v0 = valid_cycles;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'd0, cmd_valid}, 0);
    check_eq("rst_wr", {31'd0, cmd_wr}, 0);
    check_eq("rst_reg", {30'd0, cmd_reg}, 0);
    check_eq("rst_data", {24'd0, cmd_data}, 0);
    check_eq("rst_err", {31'd0, err}, 0);
    check_eq("rst_err_cnt", {24'd0, err_cnt}, 0);
    rst = 1'b0;

    // single-cycle write with ready held high
    cmd_ready = 1'b1;
    mark();
    send_str("W2:3f");
    send_byte(8'h0D);
    check_eq("w2_valid_cycles", valid_cycles - v0, 1);
    check_eq("w2_wr", {31'd0, cmd_wr}, 1);
    check_eq("w2_reg", {30'd0, cmd_reg}, 2);
    check_eq("w2_data", {24'd0, cmd_data}, 32'h3F);
    check_eq("w2_errs", err_pulses - e0, 0);

    // read held pending with ready low
    cmd_ready = 1'b0;
    mark();
    send_str("r1");
    send_byte(8'h0D);
    repeat (4) @(posedge clk);
    #1;
    check_eq("r1_held_valid", {31'd0, cmd_valid}, 1);
    check_eq("r1_wr", {31'd0, cmd_wr}, 0);
    check_eq("r1_reg", {30'd0, cmd_reg}, 1);
    check_eq("r1_data", {24'd0, cmd_data}, 0);
    check_eq("r1_stable", fld_chg, 0);
    cmd_ready = 1'b1;
    check_eq("r1_valid_at_ready", {31'd0, cmd_valid}, 1);
    @(posedge clk);
    #1;
    check_eq("r1_valid_dropped", {31'd0, cmd_valid}, 0);
    send_byte(8'h0A);
    check_eq("r1_lf_no_err", err_pulses - e0, 0);

    // short value, overlong value, then a normal read
    mark();
    send_str("W0:5");
    send_byte(8'h0D);
    check_eq("w0_data", {24'd0, cmd_data}, 32'h05);
    check_eq("w0_valid_cycles", valid_cycles - v0, 1);
    mark();
    send_str("W0:123");
    send_byte(8'h0D);
    check_eq("long_errs", err_pulses - e0, 1);
    check_eq("long_no_cmd", valid_cycles - v0, 0);
    check_eq("long_err_cnt", {24'd0, err_cnt}, 1);
    mark();
    send_str("R3");
    send_byte(8'h0D);
    check_eq("r3_valid_cycles", valid_cycles - v0, 1);
    check_eq("r3_reg", {30'd0, cmd_reg}, 3);
    check_eq("r3_wr", {31'd0, cmd_wr}, 0);
    check_eq("r3_data", {24'd0, cmd_data}, 0);

    // bad register, bad opcode, empty data
    do_reset();
    mark();
    send_str("W7:00");
    send_byte(8'h0D);
    send_str("X");
    send_byte(8'h0D);
    check_eq("bad_errs", err_pulses - e0, 2);
    check_eq("bad_err_cnt", {24'd0, err_cnt}, 2);
    check_eq("bad_no_cmd", valid_cycles - v0, 0);
    mark();
    send_str("W1:");
    send_byte(8'h0D);
    check_eq("empty_errs", err_pulses - e0, 1);
    check_eq("empty_no_cmd", valid_cycles - v0, 0);

    // inter-byte timeout
    do_reset();
    mark();
    send_str("W1:");
    repeat (135) @(posedge clk);
    #1;
    check_eq("tmo_errs", err_pulses - e0, 1);
    check_eq("tmo_latency", err_cyc - colon_edge, 100);
    send_str("AB");
    send_byte(8'h0D);
    check_eq("tmo_total_errs", err_pulses - e0, 2);
    check_eq("tmo_no_cmd", valid_cycles - v0, 0);
    check_eq("tmo_err_cnt", {24'd0, err_cnt}, 2);

    // bytes dropped while a command is pending, then reset
    cmd_ready = 1'b0;
    mark();
    send_str("W3:c7");
    send_byte(8'h0D);
    send_str("R0");
    send_byte(8'h0D);
    check_eq("pend_errs", err_pulses - e0, 3);
    check_eq("pend_err_cnt", {24'd0, err_cnt}, 5);
    check_eq("pend_valid", {31'd0, cmd_valid}, 1);
    check_eq("pend_wr", {31'd0, cmd_wr}, 1);
    check_eq("pend_reg", {30'd0, cmd_reg}, 3);
    check_eq("pend_data", {24'd0, cmd_data}, 32'hC7);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst2_out", {19'd0, cmd_valid, cmd_wr, cmd_reg, cmd_data}, 0);
    check_eq("rst2_err", {23'd0, err, err_cnt}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes the received-byte stream from the UART receive path (rx_data/rx_valid) and parses ASCII command lines typed by the operator.
- Produces one register read or write command per line toward the sequencer register file, using a valid/ready handshake.
- Malformed lines, timed-out lines and dropped bytes are discarded and reported on an error strobe and a saturating error counter.

Parameters:
- DW, 8: data width (matches seq_dp_width); must be a multiple of 4.
- NUM_REG, 4: number of addressable registers, 1..10.
- TIMEOUT_CYC, 1000000: idle cycles allowed between bytes inside a line; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid only in that cycle
- o_cmd_valid  out  1  command pending
- i_cmd_ready  in  1  consumer accepts the command
- o_cmd_wr  out  1  1 = write, 0 = read
- o_cmd_reg  out  clog2(NUM_REG), min 1  register index
- o_cmd_data  out  DW  write data; 0 for reads
- o_err  out  1  one-cycle error pulse
- o_err_cnt  out  8  saturating error count

Behaviour:
- Line grammar, case-insensitive letters:
  - "W" d ":" h{1..DW/4} EOL — write command
  - "R" d EOL — read command
  - d is an ASCII digit with value < NUM_REG; EOL is CR (0x0D) or LF (0x0A).
- Reset: state IDLE; o_cmd_valid=0, o_cmd_wr=0, o_cmd_reg=0, o_cmd_data=0, o_err=0, o_err_cnt=0. Reset mid-line or with a command pending drops everything.
- Byte handling is evaluated only in cycles where i_rx_valid=1, except in ISSUE and on timeout.
- State machine:
  - IDLE: 'W'/'w' → REG with op=wr; 'R'/'r' → REG with op=rd; CR, LF or space → stay in IDLE, no error; any other byte → DISCARD with error.
  - REG: digit with value < NUM_REG → latch reg; go to COLON if op=wr, else EOL. Anything else → DISCARD with error.
  - COLON: ':' → DATA, clearing the nibble count and data accumulator. Anything else → DISCARD with error.
  - DATA:
    - Hex digit (0-9, A-F, a-f): acc <= {acc[DW-5:0], nib}; cnt++. When cnt reaches DW/4 → EOL.
    - EOL with cnt ≥ 1 → ISSUE.
    - EOL with cnt = 0 → IDLE with error.
    - Anything else → DISCARD with error.
  - Result of the shift rule: short values are right-aligned and zero-extended, e.g. "W1:A" gives data 0x0A.
  - EOL: CR or LF → ISSUE. Anything else, including a (DW/4+1)th hex digit → DISCARD with error.
  - ISSUE:
    - o_cmd_valid=1 with fields stable; for reads o_cmd_data=0.
    - Stays in ISSUE until i_cmd_ready=1, then → IDLE with o_cmd_valid=0 on the next cycle.
    - Any byte arriving while in ISSUE is dropped with error, including in the same cycle as i_cmd_ready.
    - The companion LF of a CR-LF pair arrives after the command is taken; back in IDLE it is ignored, no error.
  - DISCARD: ignore bytes until CR or LF → IDLE, no error.
- Latency: the EOL byte accepted in cycle t gives o_cmd_valid=1 in cycle t+1 (registered). i_cmd_ready sampled high in the first ISSUE cycle gives a one-cycle valid pulse.
- Timeout:
  - A counter clears on every accepted byte and counts while in REG, COLON, DATA or EOL.
  - When it reaches TIMEOUT_CYC-1 → IDLE with error; the partial line is lost. The counter is inactive in IDLE, ISSUE and DISCARD.
  - If timeout expiry coincides with an i_rx_valid byte, the byte wins and the counter clears.
- Error:
  - o_err pulses high for exactly one cycle, the cycle after the offending event.
  - o_err_cnt increments on each pulse and saturates at 255.
  - At most one error per cycle.

Decomposition:
- Shared include (seq_definitions.v): ASCII constants (CR, LF, colon, space, 'R', 'W'), seq_dp_width, and function fnASCII2Nib returning {valid, nib[3:0]}, the inverse of the existing nibble-to-ASCII converter.
- State encodings stay local parameters.
- No sub-module; a single FSM plus counters.

Test Plan (DW=8, NUM_REG=4, TIMEOUT_CYC=100, bytes spaced ≥16 cycles):
- "W2:3f\r" with ready=1 → one cycle o_cmd_valid=1, wr=1, reg=2, data=0x3F; o_err never asserts.
- "r1\r\n" with ready held 0 for 20 cycles, then 1 → valid stays high with wr=0, reg=1, data=0 throughout; drops the cycle after ready; trailing LF gives no error.
- "W0:5\r" → data=0x05; "W0:123\r" → error on the '3', no command, o_err_cnt=1; the following "R3\r" issues normally.
- "W7:00\r" and "X\r" → two errors, o_err_cnt=2, no command; "W1:\r" → error, no command.
- "W1:" then a 150-cycle gap, then "AB\r" → timeout error ~100 cycles after ':'; 'A' in IDLE → error, DISCARD; no command; o_err_cnt=2.
- With a command pending and ready=0, send "R0\r" → three errors, fields unchanged; assert rst mid-line → all outputs 0 the next cycle, o_err_cnt=0.
